// File: rtl/pe_feeder_pkg.sv
// Shared widths, default buffer depth and FSM state encodings for pe_feeder.
package pe_feeder_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int INST_WIDTH        = 32;
    localparam int FEEDER_INST_DEPTH = 16;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_ISSUE  = 2'd1,
        FS_GAP    = 2'd2,
        FS_STREAM = 2'd3
    } fs_state_t;

endpackage

// File: rtl/pe_inst_buf.sv
// Instruction program store: one write port, one registered read port.
// A same-cycle write to the address being read is forwarded to the read data.
module pe_inst_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; the owner's count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Loads a host program, issues it to one PE, then streams a counted data block.
// Optional feature macro: PE_FEEDER_GAP_EN inserts GAP_CYCLES idle cycles before streaming.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int INST_DEPTH = FEEDER_INST_DEPTH,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         prog_v,
    input  logic [INST_WIDTH-1:0]        prog,
    output logic                         prog_rdy,
    input  logic                         start,
    input  logic [CNT_W-1:0]             n_data,
    input  logic                         data_v,
    input  logic [2*DATA_WIDTH-1:0]      data,
    output logic                         data_rdy,
    output logic                         inst_in_v,
    output logic [INST_WIDTH-1:0]        inst_in,
    output logic                         din_pe_v,
    output logic [2*DATA_WIDTH-1:0]      din_pe,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(INST_DEPTH):0]  prog_cnt
);

    localparam int          AW      = $clog2(INST_DEPTH);
    localparam logic [AW:0] DEPTH_L = INST_DEPTH[AW:0];

    if (GAP_CYCLES < 1 || INST_DEPTH != (1 << AW)) begin : g_param_check
        $error("pe_feeder: GAP_CYCLES must be >= 1 and INST_DEPTH a power of two");
    end

    fs_state_t        state;
    logic             live;
    logic [AW:0]      idx;
    logic [AW:0]      n_inst;
    logic [CNT_W-1:0] rem;
    logic             wr_en;
    logic             start_ok;
    logic             rd_en;
    logic             no_data;
    logic [AW-1:0]    rd_addr;

`ifdef PE_FEEDER_GAP_EN
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    logic [GW-1:0]            gap_cnt;
`endif

    // live keeps prog_rdy low until the first edge after reset release.
    assign prog_rdy = live && (state == FS_IDLE) && !clr && (prog_cnt < DEPTH_L);
    assign wr_en    = prog_v && prog_rdy;
    assign start_ok = (state == FS_IDLE) && start && !clr && ((prog_cnt != '0) || wr_en);
    assign rd_en    = start_ok || ((state == FS_ISSUE) && (idx < n_inst));
    assign rd_addr  = (state == FS_ISSUE) ? idx[AW-1:0] : '0;
    assign data_rdy = (state == FS_STREAM);
    assign busy     = (state != FS_IDLE);
    assign no_data  = (rem == '0);

    pe_inst_buf #(
        .DEPTH (INST_DEPTH),
        .WIDTH (INST_WIDTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (prog_cnt[AW-1:0]),
        .wr_data (prog),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (inst_in)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FS_IDLE;
            live      <= 1'b0;
            prog_cnt  <= '0;
            idx       <= '0;
            n_inst    <= '0;
            rem       <= '0;
            inst_in_v <= 1'b0;
            din_pe_v  <= 1'b0;
            din_pe    <= '0;
            done      <= 1'b0;
`ifdef PE_FEEDER_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            live      <= 1'b1;
            inst_in_v <= 1'b0;
            din_pe_v  <= 1'b0;
            done      <= 1'b0;
            case (state)
                FS_IDLE: begin
                    if (clr)        prog_cnt <= '0;
                    else if (wr_en) prog_cnt <= prog_cnt + 1'b1;
                    if (start_ok) begin
                        // Entry 0 is read on this edge, so issue resumes from index 1.
                        n_inst    <= prog_cnt + {{AW{1'b0}}, wr_en};
                        rem       <= n_data;
                        idx       <= {{AW{1'b0}}, 1'b1};
                        inst_in_v <= 1'b1;
                        state     <= FS_ISSUE;
                    end
                end
                FS_ISSUE: begin
                    if (idx < n_inst) begin
                        idx       <= idx + 1'b1;
                        inst_in_v <= 1'b1;
                    end
`ifdef PE_FEEDER_GAP_EN
                    else begin
                        gap_cnt <= '0;
                        state   <= FS_GAP;
                    end
`else
                    else if (no_data) begin
                        done  <= 1'b1;
                        state <= FS_IDLE;
                    end else begin
                        state <= FS_STREAM;
                    end
`endif
                end
`ifdef PE_FEEDER_GAP_EN
                FS_GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (no_data) begin
                        done  <= 1'b1;
                        state <= FS_IDLE;
                    end else begin
                        state <= FS_STREAM;
                    end
                end
`endif
                FS_STREAM: begin
                    if (data_v) begin
                        din_pe   <= data;
                        din_pe_v <= 1'b1;
                        rem      <= rem - 1'b1;
                        if (rem == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= FS_IDLE;
                        end
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed self-checking bench for pe_feeder; gap length follows PE_FEEDER_GAP_EN.
module tb_pe_feeder;
    import pe_feeder_pkg::*;

`ifdef PE_FEEDER_GAP_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic        clk;
    logic        rst;
    logic        clr;
    logic        prog_v;
    logic [31:0] prog;
    logic        prog_rdy;
    logic        start;
    logic [7:0]  n_data;
    logic        data_v;
    logic [31:0] data;
    logic        data_rdy;
    logic        inst_in_v;
    logic [31:0] inst_in;
    logic        din_pe_v;
    logic [31:0] din_pe;
    logic        busy;
    logic        done;
    logic [4:0]  prog_cnt;

    int          n_pass   = 0;
    int          n_checks = 0;
    logic [31:0] exp_inst [16];
    logic [31:0] exp_data [8];

    pe_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .prog_v    (prog_v),
        .prog      (prog),
        .prog_rdy  (prog_rdy),
        .start     (start),
        .n_data    (n_data),
        .data_v    (data_v),
        .data      (data),
        .data_rdy  (data_rdy),
        .inst_in_v (inst_in_v),
        .inst_in   (inst_in),
        .din_pe_v  (din_pe_v),
        .din_pe    (din_pe),
        .busy      (busy),
        .done      (done),
        .prog_cnt  (prog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        exp_inst[0] = 32'h60010080;
        exp_inst[1] = 32'h60030281;
        exp_inst[2] = 32'h60050482;
        exp_data[0] = 32'h00040002;
        exp_data[1] = 32'h00030001;
        exp_data[2] = 32'h00080006;
        exp_data[3] = 32'h00070005;
        exp_data[4] = 32'h000c000a;
        exp_data[5] = 32'h000b0009;
        for (int i = 0; i < 3; i++) begin
            prog_v = 1'b1;
            prog   = exp_inst[i];
            step();
        end
        prog_v = 1'b0;
        check("load_cnt", prog_cnt, 3);
    endtask

    // Start a run of n instructions and nd data words; send only 'sent' words.
    task automatic run(input int n, input int nd, input int sent, input bit bubble, input bit restart);
        start  = 1'b1;
        n_data = nd[7:0];
        step();
        prog_v = 1'b0;
        start  = restart;
        for (int i = 0; i < n; i++) begin
            check("inst_v", inst_in_v, 1);
            check("inst", inst_in, exp_inst[i]);
            check("busy_issue", busy, 1);
            step();
            start = 1'b0;
        end
        check("inst_v_end", inst_in_v, 0);
        for (int g = 0; g < G; g++) begin
            check("gap_rdy", data_rdy, 0);
            check("gap_done", done, 0);
            step();
        end
        if (nd == 0) begin
            check("done_nodata", done, 1);
            check("rdy_nodata", data_rdy, 0);
            check("busy_nodata", busy, 0);
            step();
            check("done_pulse", done, 0);
        end else begin
            check("rdy_rise", data_rdy, 1);
            check("din_v_pre", din_pe_v, 0);
            for (int i = 0; i < sent; i++) begin
                data_v = 1'b1;
                data   = exp_data[i];
                step();
                data_v = 1'b0;
                check("din_v", din_pe_v, 1);
                check("din", din_pe, exp_data[i]);
                check("done_beat", done, logic'(i == nd - 1));
                if (i == nd - 1) check("busy_end", busy, 0);
                if (bubble && i < sent - 1) begin
                    step();
                    check("bub_v", din_pe_v, 0);
                    check("bub_hold", din_pe, exp_data[i]);
                    check("bub_rdy", data_rdy, 1);
                end
            end
            if (sent == nd) begin
                step();
                check("done_clear", done, 0);
                check("din_v_clear", din_pe_v, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; clr = 1'b0; prog_v = 1'b0; prog = '0;
        start = 1'b0; n_data = '0; data_v = 1'b0; data = '0;

        #7;
        check("rst_prog_rdy", prog_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {inst_in_v, din_pe_v, done, data_rdy}, 0);
        check("rst_data", {inst_in, din_pe}, 0);
        check("rst_cnt", prog_cnt, 0);
        #5 rst = 1'b1;
        step();
        check("rdy_after_rst", prog_rdy, 1);

        // Basic run, then replay with n_data=0 and a stray start during ISSUE.
        load_basic();
        run(3, 6, 6, 1'b0, 1'b0);
        check("persist_cnt", prog_cnt, 3);
        run(3, 0, 0, 1'b0, 1'b1);
        check("no_restart", busy, 0);

        // Bubbles with n_data=2.
        run(3, 2, 2, 1'b1, 1'b0);

        // clr wins over same-cycle prog and start.
        clr = 1'b1; start = 1'b1; prog_v = 1'b1; prog = 32'hdeadbeef;
        #1;
        check("clr_rdy", prog_rdy, 0);
        step();
        clr = 1'b0; start = 1'b0; prog_v = 1'b0;
        check("clr_cnt", prog_cnt, 0);
        check("clr_busy", busy, 0);
        step();
        check("clr_no_run", {busy, inst_in_v}, 0);

        // start with an empty program is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        check("empty_busy", busy, 0);
        step();
        check("empty_inst_v", inst_in_v, 0);

        // A word accepted alongside start is part of the run.
        prog_v = 1'b1;
        prog = 32'h12345678;
        exp_inst[0] = 32'h12345678;
        exp_data[0] = 32'h00010002;
        run(1, 1, 1, 1'b0, 1'b0);
        check("same_cyc_cnt", prog_cnt, 1);

        // Full buffer: 16 accepted, 17th dropped, run issues 16.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_inst[i] = 32'ha5000000 | 32'(i);
            prog_v = 1'b1;
            prog   = exp_inst[i];
            step();
        end
        prog_v = 1'b0;
        check("full_cnt", prog_cnt, 16);
        check("full_rdy", prog_rdy, 0);
        prog_v = 1'b1;
        prog   = 32'hffffffff;
        step();
        prog_v = 1'b0;
        check("drop_cnt", prog_cnt, 16);
        exp_data[0] = 32'h7fff8000;
        run(16, 1, 1, 1'b0, 1'b0);

        // Reset after 3 of 6 streamed words.
        clr = 1'b1;
        step();
        clr = 1'b0;
        load_basic();
        run(3, 6, 3, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_outs", {inst_in_v, din_pe_v, done, data_rdy, busy, prog_rdy}, 0);
        check("abort_data", {inst_in, din_pe}, 0);
        check("abort_cnt", prog_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("abort_rdy", prog_rdy, 1);
        check("abort_done", done, 0);

        // Fresh load-and-run behaves as the basic run.
        load_basic();
        run(3, 6, 6, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Upstream feeder for a single `pe`: buffers a host-loaded instruction program, issues it to the PE on `inst_in_v`/`inst_in` one word per cycle, waits a fixed gap, then streams a counted block of complex data words onto `din_pe_v`/`din_pe`. It owns the load-program-then-stream sequencing for one PE, and it sits between the host/array controller and the PE.

## Interface
- `INST_DEPTH`, 16: program buffer depth in instructions (power of two).
- `GAP_CYCLES`, 2: idle cycles between the last instruction and the first data acceptance (≥1).
- `CNT_W`, 8: width of `n_data`.
- Data and instruction widths come from `DATA_WIDTH` and `INST_WIDTH` in `parameters.vh`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  clears program buffer; honoured in IDLE only.
- `prog_v`  in  1  host instruction word valid.
- `prog`  in  `INST_WIDTH`  host instruction word.
- `prog_rdy`  out  1  buffer can accept a word this cycle.
- `start`  in  1  single-cycle run request.
- `n_data`  in  `CNT_W`  data words to stream in this run; sampled with `start`.
- `data_v`  in  1  host data valid.
- `data`  in  2*`DATA_WIDTH`  complex word, real in `[31:16]`, imag in `[15:0]`.
- `data_rdy`  out  1  data accepted when `data_v && data_rdy`.
- `inst_in_v`  out  1  to the PE.
- `inst_in`  out  `INST_WIDTH`  to the PE.
- `din_pe_v`  out  1  to the PE.
- `din_pe`  out  2*`DATA_WIDTH`  to the PE.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at run completion.
- `prog_cnt`  out  log2(`INST_DEPTH`)+1  stored instruction count.

## Operation
- FSM states: IDLE → ISSUE → GAP → STREAM → IDLE.
- IDLE:
  - `prog_rdy = !clr && prog_cnt < INST_DEPTH`.
  - An accepted word is written at index `prog_cnt`, then `prog_cnt` increments.
  - `prog_v` while `prog_rdy` is low is dropped.
- `clr` in IDLE: `prog_cnt` ← 0. It wins over a same-cycle `prog_v` (word dropped) and over `start` (ignored). `clr` outside IDLE is ignored.
- `start` in IDLE:
  - With N = `prog_cnt` > 0: latch N and `n_data`, enter ISSUE.
  - With `prog_cnt` = 0: ignored.
  - A same-cycle accepted `prog` word is included, so N = `prog_cnt`+1.
  - `start` outside IDLE is ignored.
- ISSUE: issues buffer entries 0..N-1 in order, one per cycle, with `inst_in_v` = 1. Then enters GAP.
- GAP: waits `GAP_CYCLES` cycles with all valids low. Then STREAM, or IDLE with a `done` pulse if the latched `n_data` = 0.
- STREAM:
  - `data_rdy` = 1.
  - Each accepted word is registered to `din_pe`/`din_pe_v` and the remaining count decrements.
  - Host bubbles give `din_pe_v` = 0; `din_pe` holds its last value.
  - When the last word is accepted: next state IDLE, `done` pulses in the cycle that word appears on `din_pe_v`.
- The program persists after a run, so a repeated `start` replays it.

## Timing
- Reset values:
  - All outputs are 0, including `prog_rdy` during reset.
  - `prog_cnt` = 0; state is IDLE.
  - `prog_rdy` rises in the first cycle after release.
- Reset mid-run aborts immediately, with no `done` and the program lost.
- `inst_in`, `inst_in_v`, `din_pe`, `din_pe_v` and `done` are registered; `prog_rdy` and `data_rdy` are combinational from state.
- If `start` is sampled at edge k:
  - `inst_in_v` is high in cycles k+1..k+N.
  - GAP covers cycles k+N+1..k+N+`GAP_CYCLES`.
  - `data_rdy` first rises in cycle k+N+`GAP_CYCLES`+1.
- Data latency: a word accepted at edge j appears on `din_pe_v` in cycle j+1.

## Configuration
- `PE_FEEDER_GAP_EN`:
  - Defined: GAP state and `GAP_CYCLES` are active as above.
  - Undefined: GAP is removed and ISSUE goes directly to STREAM, so `data_rdy` rises in cycle k+N+1; `GAP_CYCLES` is unused.

## Structure
- `parameters.vh` gains:
  - `FEEDER_INST_DEPTH`.
  - FSM state encodings `FS_IDLE`, `FS_ISSUE`, `FS_GAP`, `FS_STREAM`.
- `DATA_WIDTH` and `INST_WIDTH` are reused from the same file.
- One sub-module, `pe_inst_buf`: `INST_DEPTH` × `INST_WIDTH` register file with one write port and one registered read port, indexed by the FSM counters.

## Test plan
- Basic run:
  - Stimulus: load 32'h60010080, 32'h60030281, 32'h60050482; `start` with `n_data`=6; stream 32'h00040002, 32'h00030001, 32'h00080006, 32'h00070005, 32'h000c000a, 32'h000b0009.
  - Response: `inst_in_v` high for 3 cycles with those words in order; after the 2-cycle gap, 6 `din_pe_v` beats with those values; `done` coincides with the last beat.
- Full buffer: write 17 words → `prog_cnt`=16, `prog_rdy` low, 17th dropped; run issues 16.
- Bubbles: `data_v` toggling 1,0,1,0 during STREAM with `n_data`=2 → `din_pe_v` pattern 0,1,0,1 (one-cycle lag); `done` with the second beat.
- Ignored requests: `start` with `prog_cnt`=0 → `busy` stays 0. `start` during ISSUE → ignored, run unchanged. `clr`+`start` same cycle → `prog_cnt`=0, no run.
- Reset mid-STREAM after 3 of 6 words: all outputs 0, no `done`, `prog_cnt`=0; a fresh load-and-run afterwards behaves as the basic run.
- `n_data`=0: 3 instructions issued, gap, `done` with no `din_pe_v` beats. With `PE_FEEDER_GAP_EN` undefined, `data_rdy` rises the cycle after the last instruction.
